// File: rtl/cpu_mc_if.sv
`default_nettype none
// ============================================================================
// cpu_mc_if : shared instruction/data memory port with request/ready handshake
// Revision   : 1.0
// ============================================================================
interface cpu_mc_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/cpu_mc.sv
`default_nettype none
// ============================================================================
// cpu_mc   : multi-cycle core, fetch/decode/exec/mem/wb over one memory port
// Revision : 1.0
// ============================================================================
module cpu_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREG     = 32
) (
    input  logic        clk,
    input  logic        reset,
    cpu_mc_if.master    bus,
    output logic [31:0] pc,
    output logic        halted,
    output logic [31:0] retired
);
    localparam int RW = $clog2(NREG);

    localparam logic [2:0] S_BOOT   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALTED = 3'd6;

    localparam logic [6:0] OP_ADD  = 7'h00;
    localparam logic [6:0] OP_SUB  = 7'h01;
    localparam logic [6:0] OP_AND  = 7'h02;
    localparam logic [6:0] OP_OR   = 7'h03;
    localparam logic [6:0] OP_SLT  = 7'h04;
    localparam logic [6:0] OP_ADDI = 7'h10;
    localparam logic [6:0] OP_LW   = 7'h20;
    localparam logic [6:0] OP_SW   = 7'h21;
    localparam logic [6:0] OP_BEQ  = 7'h30;
    localparam logic [6:0] OP_J    = 7'h38;
    localparam logic [6:0] OP_HALT = 7'h7F;

    logic [2:0]    state;
    logic [31:0]   ir, a, b, alu_out, mdr;
    logic [31:0]   regs [NREG];
    logic          req_q, we_q;
    logic [31:0]   addr_q, wdata_q;

    logic [6:0]    op;
    logic [RW-1:0] rd_i, rs_i, rt_i;
    logic [31:0]   imm, jtarget, br_target, next_pc, alu_res;

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    // pc already holds the fetch address + 4 from DECODE onward
    assign op        = ir[31:25];
    assign rd_i      = ir[20 +: RW];
    assign rs_i      = ir[15 +: RW];
    assign rt_i      = ir[10 +: RW];
    assign imm       = {{17{ir[14]}}, ir[14:0]};
    assign jtarget   = {pc[31:27], ir[24:0], 2'b00};
    assign br_target = pc + {imm[29:0], 2'b00};
    assign next_pc   = (op == OP_J) ? jtarget : ((a == b) ? br_target : pc);

    always_comb begin
        alu_res = 32'd0;
        case (op)
            OP_ADD:       alu_res = a + b;
            OP_SUB:       alu_res = a - b;
            OP_AND:       alu_res = a & b;
            OP_OR:        alu_res = a | b;
            OP_SLT:       alu_res = {31'd0, $signed(a) < $signed(b)};
            OP_ADDI:      alu_res = a + imm;
            OP_LW, OP_SW: alu_res = (a + imm) & ~32'h3;
            default:      alu_res = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= 32'd0;
        end else if (state == S_WB && rd_i != '0) begin
            regs[rd_i] <= (op == OP_LW) ? mdr : alu_out;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_BOOT;
            pc      <= RESET_PC;
            ir      <= 32'd0;
            a       <= 32'd0;
            b       <= 32'd0;
            alu_out <= 32'd0;
            mdr     <= 32'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            halted  <= 1'b0;
            retired <= 32'd0;
        end else begin
            case (state)
                S_BOOT: begin
                    req_q  <= 1'b1;
                    we_q   <= 1'b0;
                    addr_q <= pc;
                    state  <= S_FETCH;
                end
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        ir    <= bus.mem_rdata;
                        pc    <= pc + 32'd4;
                        req_q <= 1'b0;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a <= regs[rs_i];
                    b <= (op == OP_SW || op == OP_BEQ) ? regs[rd_i] : regs[rt_i];
                    if (op == OP_HALT) begin
                        halted  <= 1'b1;
                        retired <= retired + 32'd1;
                        state   <= S_HALTED;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    if (op == OP_BEQ || op == OP_J) begin
                        pc      <= next_pc;
                        addr_q  <= next_pc;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        retired <= retired + 32'd1;
                        state   <= S_FETCH;
                    end else if (op == OP_LW || op == OP_SW) begin
                        addr_q  <= alu_res;
                        we_q    <= (op == OP_SW);
                        wdata_q <= b;
                        req_q   <= 1'b1;
                        state   <= S_MEM;
                    end else if (op <= OP_SLT || op == OP_ADDI) begin
                        state <= S_WB;
                    end else begin
                        addr_q  <= pc;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        retired <= retired + 32'd1;
                        state   <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        we_q <= 1'b0;
                        if (op == OP_SW) begin
                            // back-to-back request: the next fetch starts immediately
                            addr_q  <= pc;
                            retired <= retired + 32'd1;
                            state   <= S_FETCH;
                        end else begin
                            mdr   <= bus.mem_rdata;
                            req_q <= 1'b0;
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    addr_q  <= pc;
                    req_q   <= 1'b1;
                    we_q    <= 1'b0;
                    retired <= retired + 32'd1;
                    state   <= S_FETCH;
                end
                S_HALTED: begin
                    req_q <= 1'b0;
                end
                default: begin
                    req_q <= 1'b0;
                    state <= S_BOOT;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cpu_mc.sv
`default_nettype none
// ============================================================================
// tb_cpu_mc : directed programs against two cpu_mc instances with memory models
// Revision  : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_cpu_mc;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cpu_mc_if bus1 ();
    cpu_mc_if bus2 ();
    logic [31:0] pc1, ret1, pc2, ret2;
    logic        halt1, halt2;

    cpu_mc #(.RESET_PC(32'h0000_0000), .NREG(32)) dut (
        .clk(clk), .reset(reset), .bus(bus1.master),
        .pc(pc1), .halted(halt1), .retired(ret1)
    );
    cpu_mc #(.RESET_PC(32'h0000_0100), .NREG(8)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.master),
        .pc(pc2), .halted(halt2), .retired(ret2)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] mem1 [256];
    logic [31:0] mem2 [256];
    int          wait_n = 0;
    int          wcnt = 0;
    int          stab_err = 0;
    logic        stalled_prev = 1'b0;
    logic [31:0] a_prev, d_prev;
    logic        we_prev;

    // memory 1: configurable wait states plus request-stability monitor
    always @(negedge clk) begin
        if (!reset) begin
            stalled_prev   = 1'b0;
            wcnt           = 0;
            bus1.mem_ready = 1'b0;
        end else begin
            if (stalled_prev && (bus1.mem_req !== 1'b1 || bus1.mem_addr !== a_prev ||
                                 bus1.mem_we !== we_prev || bus1.mem_wdata !== d_prev))
                stab_err++;
            if (bus1.mem_req === 1'b1 && bus1.mem_addr[1:0] !== 2'b00) stab_err++;
            if (bus1.mem_req === 1'b1 && wcnt < wait_n) begin
                bus1.mem_ready = 1'b0;
                wcnt++;
            end else if (bus1.mem_req === 1'b1) begin
                bus1.mem_ready = 1'b1;
                bus1.mem_rdata = mem1[bus1.mem_addr[9:2]];
                wcnt = 0;
            end else begin
                bus1.mem_ready = 1'b0;
                wcnt = 0;
            end
            stalled_prev = bus1.mem_req && !bus1.mem_ready;
            a_prev  = bus1.mem_addr;
            d_prev  = bus1.mem_wdata;
            we_prev = bus1.mem_we;
        end
    end

    always @(posedge clk)
        if (reset && bus1.mem_req && bus1.mem_ready && bus1.mem_we)
            mem1[bus1.mem_addr[9:2]] = bus1.mem_wdata;

    always @(negedge clk) begin
        bus2.mem_ready = bus2.mem_req;
        bus2.mem_rdata = mem2[bus2.mem_addr[9:2]];
    end

    always @(posedge clk)
        if (reset && bus2.mem_req && bus2.mem_ready && bus2.mem_we)
            mem2[bus2.mem_addr[9:2]] = bus2.mem_wdata;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ei(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [14:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [31:0] er(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 10'd0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem1();
        for (int i = 0; i < 256; i++) mem1[i] = 32'hDEAD_BEEF;
    endtask

    task automatic enter_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_to_halt(input int start, input int limit, output int cyc);
        cyc = start;
        while (halt1 !== 1'b1 && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    localparam logic [31:0] HALT = {7'h7F, 25'd0};
    int cyc;
    int found;

    initial begin
        bus1.mem_ready = 1'b0; bus1.mem_rdata = 32'd0;
        bus2.mem_ready = 1'b0; bus2.mem_rdata = 32'd0;
        for (int i = 0; i < 256; i++) mem2[i] = 32'd0;
        mem2[64] = ei(7'h10, 5'd9, 5'd0, 15'd9);
        mem2[65] = ei(7'h21, 5'd1, 5'd0, 15'h80);
        mem2[66] = HALT;

        // program 1: ALU ops, results stored, zero wait states
        clear_mem1();
        mem1[0] = ei(7'h10, 5'd1, 5'd0, 15'd5);
        mem1[1] = ei(7'h10, 5'd2, 5'd0, 15'h7FFD);
        mem1[2] = er(7'h00, 5'd3, 5'd1, 5'd2);
        mem1[3] = er(7'h01, 5'd4, 5'd1, 5'd2);
        mem1[4] = er(7'h04, 5'd5, 5'd2, 5'd1);
        mem1[5] = ei(7'h21, 5'd3, 5'd0, 15'h80);
        mem1[6] = ei(7'h21, 5'd4, 5'd0, 15'h84);
        mem1[7] = ei(7'h21, 5'd5, 5'd0, 15'h88);
        mem1[8] = HALT;
        wait_n = 0;
        enter_reset();
        #1;
        check("rst_pc", pc1, 32'h0);
        check("rst_halted", {31'd0, halt1}, 32'd0);
        check("rst_retired", ret1, 32'd0);
        check("rst_req", {31'd0, bus1.mem_req}, 32'd0);
        check("rst_we", {31'd0, bus1.mem_we}, 32'd0);
        check("rst_addr", bus1.mem_addr, 32'd0);
        check("rst_wdata", bus1.mem_wdata, 32'd0);
        check("rst_pc2", pc2, 32'h100);
        release_reset();
        @(posedge clk);
        #1;
        check("first_req", {31'd0, bus1.mem_req}, 32'd1);
        check("first_addr", bus1.mem_addr, 32'h0);
        check("first_we", {31'd0, bus1.mem_we}, 32'd0);
        check("n8_first_req", {31'd0, bus2.mem_req}, 32'd1);
        check("n8_first_addr", bus2.mem_addr, 32'h100);
        run_to_halt(1, 500, cyc);
        check("p1_halted", {31'd0, halt1}, 32'd1);
        check("p1_cycles", cyc, 32'd35);
        check("p1_retired", ret1, 32'd9);
        check("p1_pc", pc1, 32'h24);
        check("p1_add", mem1[32], 32'd2);
        check("p1_sub", mem1[33], 32'd8);
        check("p1_slt", mem1[34], 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("p1_halt_noreq", {31'd0, bus1.mem_req}, 32'd0);
        check("p1_halt_retired", ret1, 32'd9);
        check("n8_reg_alias", mem2[32], 32'd9);
        check("n8_retired", ret2, 32'd3);
        check("n8_pc", pc2, 32'h10C);
        check("n8_halted", {31'd0, halt2}, 32'd1);

        // program 2: store/load through 3 wait states, unaligned load offset
        enter_reset();
        clear_mem1();
        mem1[0] = ei(7'h10, 5'd1, 5'd0, 15'd5);
        mem1[1] = ei(7'h21, 5'd1, 5'd0, 15'h40);
        mem1[2] = ei(7'h20, 5'd6, 5'd0, 15'h43);
        mem1[3] = ei(7'h21, 5'd6, 5'd0, 15'h44);
        mem1[4] = HALT;
        wait_n = 3;
        stab_err = 0;
        release_reset();
        run_to_halt(0, 500, cyc);
        check("p2_halted", {31'd0, halt1}, 32'd1);
        check("p2_cycles", cyc, 32'd44);
        check("p2_retired", ret1, 32'd5);
        check("p2_sw", mem1[16], 32'd5);
        check("p2_lw", mem1[17], 32'd5);
        check("p2_stable", stab_err, 32'd0);

        // program 3: branches, jump, r0 discard, undefined opcode
        enter_reset();
        clear_mem1();
        mem1[0]  = ei(7'h10, 5'd1, 5'd0, 15'd5);
        mem1[1]  = ei(7'h10, 5'd2, 5'd0, 15'h7FFD);
        mem1[2]  = ei(7'h30, 5'd1, 5'd1, 15'd2);
        mem1[3]  = ei(7'h10, 5'd3, 5'd0, 15'd1);
        mem1[4]  = ei(7'h10, 5'd3, 5'd0, 15'd2);
        mem1[5]  = ei(7'h30, 5'd2, 5'd1, 15'd2);
        mem1[6]  = {7'h38, 25'h10};
        mem1[7]  = HALT;
        mem1[16] = ei(7'h10, 5'd0, 5'd0, 15'd7);
        mem1[17] = er(7'h00, 5'd7, 5'd0, 5'd0);
        mem1[18] = {7'h55, 5'd7, 5'd1, 15'd5};
        mem1[19] = ei(7'h21, 5'd3, 5'd0, 15'h80);
        mem1[20] = ei(7'h21, 5'd7, 5'd0, 15'h84);
        mem1[21] = ei(7'h21, 5'd0, 5'd0, 15'h88);
        mem1[22] = HALT;
        wait_n = 0;
        release_reset();
        run_to_halt(0, 500, cyc);
        check("p3_halted", {31'd0, halt1}, 32'd1);
        check("p3_cycles", cyc, 32'd43);
        check("p3_retired", ret1, 32'd12);
        check("p3_pc", pc1, 32'h5C);
        check("p3_beq_skip", mem1[32], 32'd0);
        check("p3_r7_nop", mem1[33], 32'd0);
        check("p3_r0", mem1[34], 32'd0);

        // program 4: reset asserted during a stalled store
        enter_reset();
        clear_mem1();
        mem1[0] = ei(7'h10, 5'd1, 5'd0, 15'd5);
        mem1[1] = ei(7'h21, 5'd1, 5'd0, 15'h40);
        mem1[2] = HALT;
        wait_n = 20;
        release_reset();
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            @(negedge clk);
            if (bus1.mem_req === 1'b1 && bus1.mem_we === 1'b1) found = 1;
        end
        check("p4_store_seen", found, 32'd1);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("p4_req_drop", {31'd0, bus1.mem_req}, 32'd0);
        check("p4_pc", pc1, 32'h0);
        check("p4_retired", ret1, 32'd0);
        repeat (2) @(posedge clk);
        release_reset();
        @(posedge clk);
        #1;
        check("p4_refetch_req", {31'd0, bus1.mem_req}, 32'd1);
        check("p4_refetch_addr", bus1.mem_addr, 32'h0);
        check("p4_refetch_we", {31'd0, bus1.mem_we}, 32'd0);
        check("p4_no_store", mem1[16], 32'hDEAD_BEEF);
        check("stable_total", stab_err, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
